// File: rtl/beam_scan_ctrl.sv
// beam_scan_ctrl: sequences the delay-and-sum power datapath across NUM_DIR
// steering directions per frame. It accumulates power per direction over
// NUM_FRAMES frames, then reports the direction with the highest total power.
//
// Ports:
//   i_clk, i_rst       clock; synchronous active-high reset
//   i_start            one-cycle pulse, begins a scan when idle
//   i_abort            return to idle, no ack/done, results retained
//   i_frame_valid      upstream frame available (held through ack)
//   o_frame_ack        one-cycle pulse, frame consumed
//   o_dir_idx          steering direction presented to the delay unit
//   i_power            17-bit squared beam power
//   o_busy             high outside IDLE
//   o_done             one-cycle pulse at scan completion
//   o_best_dir         winning direction
//   o_best_power       accumulated power of the winning direction
//
// Optional feature: define BEAM_SCAN_SATURATE_EN to clamp accumulators at
// 2^ACC_W-1. When it is not defined, the accumulators wrap modulo 2^ACC_W.
module beam_scan_ctrl #(
   parameter int unsigned NUM_DIR    = 8,
   parameter int unsigned NUM_FRAMES = 64,
   parameter int unsigned SETTLE     = 2,
   parameter int unsigned ACC_W      = 24
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic                       i_abort,
   input  logic                       i_frame_valid,
   output logic                       o_frame_ack,
   output logic [$clog2(NUM_DIR)-1:0] o_dir_idx,
   input  logic [16:0]                i_power,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [$clog2(NUM_DIR)-1:0] o_best_dir,
   output logic [ACC_W-1:0]           o_best_power
);

   localparam int unsigned DIR_W = $clog2(NUM_DIR);
   localparam int unsigned FR_W  = $clog2(NUM_FRAMES + 1);
   localparam int unsigned ST_W  = $clog2(SETTLE + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_STEER, S_ACK, S_CMP, S_DONE
   } state_t;

   state_t            r_state;
   logic [DIR_W-1:0]  r_dir;
   logic [DIR_W-1:0]  r_cmp;
   logic [ST_W-1:0]   r_cnt;
   logic [FR_W-1:0]   r_frames;
   logic [ACC_W-1:0]  r_acc [NUM_DIR];
   logic [DIR_W-1:0]  r_cand_dir;
   logic [ACC_W-1:0]  r_cand_pow;
   logic              r_ack;
   logic              r_busy;
   logic              r_done;
   logic [DIR_W-1:0]  r_best_dir;
   logic [ACC_W-1:0]  r_best_pow;

   logic [ACC_W-1:0]  w_add;
   logic [ACC_W-1:0]  w_cmp_val;
   logic              w_take;

   // Accumulator update for the currently steered direction
`ifdef BEAM_SCAN_SATURATE_EN
   logic [ACC_W:0] w_sum;
   assign w_sum = {1'b0, r_acc[r_dir]} + (ACC_W+1)'(i_power);
   assign w_add = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
   assign w_add = r_acc[r_dir] + ACC_W'(i_power);
`endif

   // Index 0 always seeds the candidate; later entries must be strictly greater
   assign w_cmp_val = r_acc[r_cmp];
   assign w_take    = (r_cmp == '0) || (w_cmp_val > r_cand_pow);

   // Scan sequencer
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_dir      <= '0;
         r_cmp      <= '0;
         r_cnt      <= '0;
         r_frames   <= '0;
         r_cand_dir <= '0;
         r_cand_pow <= '0;
         r_ack      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_best_dir <= '0;
         r_best_pow <= '0;
         for (int i = 0; i < int'(NUM_DIR); i++) r_acc[i] <= '0;
      end else if (i_abort) begin
         r_state <= S_IDLE;
         r_dir   <= '0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_ack  <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  for (int i = 0; i < int'(NUM_DIR); i++) r_acc[i] <= '0;
                  r_frames <= '0;
                  r_dir    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_frame_valid) begin
                  r_dir   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_STEER;
               end
            end
            S_STEER: begin
               // Power is sampled on the last settle cycle of each direction
               if (r_cnt == ST_W'(SETTLE - 1)) begin
                  r_acc[r_dir] <= w_add;
                  r_cnt        <= '0;
                  if (r_dir == DIR_W'(NUM_DIR - 1)) begin
                     r_dir   <= '0;
                     r_ack   <= 1'b1;
                     r_state <= S_ACK;
                  end else begin
                     r_dir <= r_dir + DIR_W'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + ST_W'(1);
               end
            end
            S_ACK: begin
               r_frames <= r_frames + FR_W'(1);
               if (r_frames == FR_W'(NUM_FRAMES - 1)) begin
                  r_cmp   <= '0;
                  r_state <= S_CMP;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_CMP: begin
               if (w_take) begin
                  r_cand_dir <= r_cmp;
                  r_cand_pow <= w_cmp_val;
               end
               // Final entry: publish the winner so it is visible with o_done
               if (r_cmp == DIR_W'(NUM_DIR - 1)) begin
                  r_best_dir <= w_take ? r_cmp : r_cand_dir;
                  r_best_pow <= w_take ? w_cmp_val : r_cand_pow;
                  r_done     <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_cmp <= r_cmp + DIR_W'(1);
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_frame_ack  = r_ack;
   assign o_dir_idx    = r_dir;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_best_dir   = r_best_dir;
   assign o_best_power = r_best_pow;

endmodule

// File: doc/beam_scan_ctrl.md
Name: beam_scan_ctrl

Overview:
- Sequences the 16-mic delay-and-sum power datapath across a set of steering directions.
- For each incoming sample frame, presents every direction index to the delay unit in turn, waits for the summed-and-squared power to settle, and adds it to a per-direction accumulator.
- After NUM_FRAMES frames, scans the accumulators and reports the direction with the highest accumulated power.
- Sits between the mic sample buffer (frame handshake) and the delay/Add_Square power path (direction index out, 17-bit power in).

Parameters:
- NUM_DIR, 8, number of steering directions, at least 2.
- NUM_FRAMES, 64, frames accumulated per scan, at least 1.
- SETTLE, 2, cycles from an o_dir_idx change until i_power is valid, at least 1.
- ACC_W, 24, accumulator width, at least 17.

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle pulse; begins a scan when the block is idle.
- i_abort  in  1  returns the block to IDLE without asserting o_done.
- i_frame_valid  in  1  upstream holds the 16 mic samples stable while this is high.
- o_frame_ack  out  1  one-cycle pulse; the current frame is consumed.
- o_dir_idx  out  $clog2(NUM_DIR)  steering direction index to the delay unit.
- i_power  in  17  squared beam power from the power datapath.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when a scan completes.
- o_best_dir  out  $clog2(NUM_DIR)  winning direction.
- o_best_power  out  ACC_W  accumulated power of the winning direction.

Behaviour:
- Reset values: all outputs 0, state IDLE, accumulators 0, counters 0.
- IDLE
  - i_start: clear all accumulators and the frame counter, go to WAIT_FRAME.
  - i_start is ignored in every other state.
- WAIT_FRAME
  - o_dir_idx = 0.
  - i_frame_valid=1: go to STEER with dir=0 and settle counter=0.
- STEER
  - o_dir_idx = dir.
  - Settle counter increments each cycle.
  - When the counter reaches SETTLE-1, i_power is sampled on that edge and acc[dir] += i_power (zero-extended).
  - If dir < NUM_DIR-1: dir+1, counter reset to 0, stay in STEER. Otherwise go to ACK.
  - Each frame occupies exactly NUM_DIR*SETTLE cycles in STEER.
- ACK
  - o_frame_ack=1 for one cycle; frame counter increments.
  - If the counter equals NUM_FRAMES, go to COMPARE; else go to WAIT_FRAME.
  - Upstream must hold samples stable from i_frame_valid high through the ACK cycle.
  - i_frame_valid outside WAIT_FRAME has no effect.
- COMPARE
  - One accumulator per cycle, idx 0..NUM_DIR-1, so NUM_DIR cycles.
  - The candidate is replaced only on strictly greater power, so ties resolve to the lowest index.
  - Then go to DONE.
- DONE
  - o_done=1 for one cycle; o_best_dir and o_best_power update on this cycle.
  - Go to IDLE.
  - Results hold until the next DONE or reset.
- Accumulator overflow behaviour is set by the optional feature below.
- i_abort in any state: go to IDLE next cycle, no ack or done pulse, previous results retained. i_abort takes priority over i_start and i_frame_valid.
- i_rst mid-scan: immediate full clear, including the results registers.

Optional Feature:
- BEAM_SCAN_SATURATE_EN defined: accumulator additions clamp at 2^ACC_W-1.
- Undefined: additions wrap modulo 2^ACC_W.

Test Plan:
- Basic scan. NUM_DIR=4, NUM_FRAMES=2, SETTLE=2, ACC_W=24. Power model per direction {10,50,30,20}, frame_valid always high -> single o_done, o_best_dir=1, o_best_power=100, exactly 2 o_frame_ack pulses, and 8 STEER cycles between WAIT_FRAME exit and ACK for each frame.
- Tie. Same configuration, power {40,40,10,0} -> o_best_dir=0, o_best_power=80.
- Handshake stall. i_frame_valid held low for 5 cycles after start -> o_busy=1, o_dir_idx=0, no ack. Then valid high -> o_dir_idx sequence 0,0,1,1,2,2,3,3 and then one ack.
- Overflow. ACC_W=18, NUM_FRAMES=3, power 0x1FFFF on all directions -> with BEAM_SCAN_SATURATE_EN, o_best_power=0x3FFFF; without it, 0x1FFFD. o_best_dir=0 in both cases.
- Abort and reset mid-scan.
  - i_abort during frame 1 STEER -> o_busy=0 next cycle, no o_done, prior o_best_* unchanged.
  - i_rst mid-scan -> all outputs 0.
  - A new i_start then gives correct results, with no residue from the aborted scan.
- Start while busy. A second i_start pulse during STEER and during COMPARE -> ignored; exactly one o_done for the scan.
